// File: rtl/conv1d_engine_pkg.sv
// rtl/conv1d_engine_pkg.sv - shared types, constants and saturation helper for conv1d_engine
// Contents:
//   state_e     engine FSM states
//   conv_cfg_t  configuration latched on an accepted start (address fields sized for
//               any supported SRAM depth; only the low ADDR_W bits are meaningful)
//   MAX_K       maximum kernel taps, TAP_IW tap index width
//   SAMPLE_W    sample / weight width
//   sat32       clamp a signed 64-bit value into signed 32-bit range
package conv1d_engine_pkg;

    localparam int MAX_K    = 8;
    localparam int TAP_IW   = $clog2(MAX_K);
    localparam int SAMPLE_W = 16;
    localparam int CFG_AW   = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD_W,
        MAC,
        WRITE,
        FINISH
    } state_e;

    typedef struct packed {
        logic [CFG_AW-1:0] in_base;
        logic [CFG_AW:0]   in_len;
        logic [CFG_AW-1:0] w_base;
        logic [3:0]        k_len;
        logic [CFG_AW-1:0] out_base;
        logic              pad_mode;
        logic [4:0]        shift;
    } conv_cfg_t;

    function automatic logic [31:0] sat32(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF) begin
            return 32'h7FFF_FFFF;
        end else if (v < -64'sh0000_0000_8000_0000) begin
            return 32'h8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/conv1d_engine_if.sv
// rtl/conv1d_engine_if.sv - single-port SRAM bus between the conv1d engine and the memory
// Signals:
//   req    request strobe (read when we=0, write when we=1)
//   we     write enable; byte enables are implicitly all ones
//   addr   word address
//   wdata  write data
//   rdata  read data, valid the cycle after a read request
// Modports: master (engine side), slave (memory side)
interface conv1d_engine_if #(
    parameter int ADDR_W = 7
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output req, output we, output addr, output wdata, input rdata);
    modport slave  (input req, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/conv1d_mac.sv
// rtl/conv1d_mac.sv - signed 16x16 multiply-accumulate with shift-and-saturate result
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         zero the accumulator (takes priority over en_i)
//   en_i            add a_i*b_i into the accumulator
//   a_i, b_i        signed operands
//   shift_i         arithmetic right shift applied to the accumulator on output
//   result_o        sat32(acc >>> shift_i), combinational from the accumulator
module conv1d_mac
    import conv1d_engine_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] a_i,
    input  logic signed [SAMPLE_W-1:0] b_i,
    input  logic [4:0]                 shift_i,
    output logic [31:0]                result_o
);

    logic signed [2*SAMPLE_W-1:0] prod;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [63:0]           acc_ext;
    logic signed [63:0]           acc_shr;

    assign prod = a_i * b_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + $signed({{(ACC_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod});
        end
    end

    assign acc_ext  = $signed({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q});
    assign acc_shr  = acc_ext >>> shift_i;
    assign result_o = sat32(acc_shr);

endmodule

// File: rtl/conv1d_engine.sv
// rtl/conv1d_engine.sv - 1D convolution engine over a shared single-port SRAM
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   start_i               start pulse, accepted only in IDLE
//   in_base_i, in_len_i   input sample window (word address, sample count)
//   w_base_i, k_len_i     weight window (word address, taps 1..MAX_K)
//   out_base_i            first output word
//   pad_mode_i            0 = valid, 1 = same (zero padded)
//   shift_i               arithmetic right shift of the accumulator before saturation
//   busy_o, done_o        active flag, one-cycle completion pulse
//   err_o                 sticky configuration error, cleared by the next accepted start
//   ext_gnt_o             1 = SRAM belongs to the external bridge
//   mem                   SRAM master port (samples/weights in rdata[15:0])
module conv1d_engine
    import conv1d_engine_pkg::*;
#(
    parameter int NUM_WORDS = 128,
    parameter int ADDR_W    = $clog2(NUM_WORDS),
    parameter int ACC_W     = 40
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W:0]   in_len_i,
    input  logic [ADDR_W-1:0] w_base_i,
    input  logic [3:0]        k_len_i,
    input  logic [ADDR_W-1:0] out_base_i,
    input  logic              pad_mode_i,
    input  logic [4:0]        shift_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              ext_gnt_o,
    conv1d_engine_if.master   mem
);

    state_e                     state_q, state_d;
    conv_cfg_t                  cfg_q, cfg_new;
    logic [3:0]                 cnt_q;
    logic [CFG_AW:0]            out_idx_q;
    logic                       err_q;
    logic signed [SAMPLE_W-1:0] taps_q [MAX_K];

    // Read-valid pipeline: remembers what the previous cycle's read was for.
    logic                       w_pend_q;
    logic                       s_pend_q;
    logic                       s_zero_q;
    logic [TAP_IW-1:0]          pend_tap_q;

    logic                       cfg_err;
    logic [3:0]                 pad;
    logic [CFG_AW:0]            n_out;
    logic signed [CFG_AW+2:0]   s_idx;
    logic                       s_in_range;
    logic                       tap_phase;
    logic                       mac_clear;
    logic signed [SAMPLE_W-1:0] mac_b;
    logic [31:0]                mac_result;
    logic                       unused_rdata_hi;

    assign unused_rdata_hi = ^mem.rdata[31:SAMPLE_W];

    always_comb begin
        cfg_new                        = '0;
        cfg_new.in_base[ADDR_W-1:0]    = in_base_i;
        cfg_new.in_len[ADDR_W:0]       = in_len_i;
        cfg_new.w_base[ADDR_W-1:0]     = w_base_i;
        cfg_new.k_len                  = k_len_i;
        cfg_new.out_base[ADDR_W-1:0]   = out_base_i;
        cfg_new.pad_mode               = pad_mode_i;
        cfg_new.shift                  = shift_i;
    end

    assign cfg_err = (cfg_q.k_len == 4'd0) || (cfg_q.k_len > 4'(MAX_K)) ||
                     (cfg_q.in_len == '0) ||
                     (!cfg_q.pad_mode && (cfg_q.in_len < (CFG_AW+1)'(cfg_q.k_len)));

    assign pad   = cfg_q.pad_mode ? ((cfg_q.k_len - 4'd1) >> 1) : 4'd0;
    assign n_out = cfg_q.pad_mode ? cfg_q.in_len
                                  : cfg_q.in_len - (CFG_AW+1)'(cfg_q.k_len) + (CFG_AW+1)'(1);

    // Sample index for the current output/tap; negative or past in_len means a zero pad.
    assign s_idx      = $signed({2'b00, out_idx_q}) + $signed({{(CFG_AW-1){1'b0}}, cnt_q})
                      - $signed({{(CFG_AW-1){1'b0}}, pad});
    assign s_in_range = !s_idx[CFG_AW+2] && (s_idx[CFG_AW+1:0] < {1'b0, cfg_q.in_len});
    assign tap_phase  = (cnt_q < cfg_q.k_len);

    always_comb begin
        state_d    = state_q;
        mem.req    = 1'b0;
        mem.we     = 1'b0;
        mem.addr   = '0;
        mem.wdata  = '0;
        mac_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = CHECK;
            end
            CHECK: begin
                state_d = cfg_err ? FINISH : LOAD_W;
            end
            LOAD_W: begin
                if (tap_phase) begin
                    mem.req  = 1'b1;
                    mem.addr = ADDR_W'(cfg_q.w_base + CFG_AW'(cnt_q));
                end else begin
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_clear = (cnt_q == 4'd0);
                if (tap_phase) begin
                    if (s_in_range) begin
                        mem.req  = 1'b1;
                        mem.addr = ADDR_W'(cfg_q.in_base + s_idx[CFG_AW-1:0]);
                    end
                end else begin
                    // Extra cycle lets the last tap's read data reach the accumulator.
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem.req   = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = ADDR_W'(cfg_q.out_base + out_idx_q[CFG_AW-1:0]);
                mem.wdata = mac_result;
                state_d   = (out_idx_q + (CFG_AW+1)'(1) == n_out) ? FINISH : MAC;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            cnt_q      <= '0;
            out_idx_q  <= '0;
            err_q      <= 1'b0;
            w_pend_q   <= 1'b0;
            s_pend_q   <= 1'b0;
            s_zero_q   <= 1'b0;
            pend_tap_q <= '0;
            for (int i = 0; i < MAX_K; i++) taps_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            w_pend_q   <= (state_q == LOAD_W) && tap_phase;
            s_pend_q   <= (state_q == MAC) && tap_phase;
            s_zero_q   <= !s_in_range;
            pend_tap_q <= cnt_q[TAP_IW-1:0];
            if (w_pend_q) taps_q[pend_tap_q] <= mem.rdata[SAMPLE_W-1:0];
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cfg_q     <= cfg_new;
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                        out_idx_q <= '0;
                    end
                end
                CHECK: begin
                    err_q <= cfg_err;
                    cnt_q <= '0;
                end
                LOAD_W, MAC: begin
                    cnt_q <= tap_phase ? cnt_q + 4'd1 : 4'd0;
                end
                WRITE: begin
                    out_idx_q <= out_idx_q + (CFG_AW+1)'(1);
                    cnt_q     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mac_b = s_zero_q ? '0 : $signed(mem.rdata[SAMPLE_W-1:0]);

    conv1d_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (mac_clear),
        .en_i     (s_pend_q),
        .a_i      (taps_q[pend_tap_q]),
        .b_i      (mac_b),
        .shift_i  (cfg_q.shift),
        .result_o (mac_result)
    );

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == FINISH);
    assign err_o     = err_q;
    assign ext_gnt_o = (state_q == IDLE) || (state_q == CHECK) || (state_q == FINISH);

endmodule
